// File: rtl/bvashr_cmp_skolem_seq_pkg.sv
// Shared types for the sequential ashr/compare Skolem witness generator.
// Holds the comparison encoding and the FSM state encoding.
package skolem_pkg;

  typedef enum logic [1:0] {
    CMP_SLE = 2'd0,
    CMP_SLT = 2'd1,
    CMP_SGE = 2'd2,
    CMP_SGT = 2'd3
  } cmp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESP
  } state_e;

endpackage

// File: rtl/bvashr_cmp_skolem_seq_ashr_cmp.sv
// Combinational predicate p = (s >>> x) CMP t.
// The shift is arithmetic and the compare is signed over the full width.
module skolem_ashr_cmp
  import skolem_pkg::*;
#(
  parameter  int W  = 4,
  localparam int XW = $clog2(W)
) (
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  t,
  input  logic [XW-1:0] x,
  input  cmp_e          cmp,
  output logic          p
);

  logic signed [W-1:0] shifted;
  logic signed [W-1:0] bound;

  assign shifted = $signed(s) >>> x;
  assign bound   = $signed(t);

  always_comb begin
    p = 1'b0;
    case (cmp)
      CMP_SLE: p = (shifted <= bound);
      CMP_SLT: p = (shifted <  bound);
      CMP_SGE: p = (shifted >= bound);
      CMP_SGT: p = (shifted >  bound);
      default: p = 1'b0;
    endcase
  end

endmodule

// File: rtl/bvashr_cmp_skolem_seq.sv
// Sequential Skolem witness search: smallest x in [0, W-1] with (s >>> x) CMP t.
// Optional macro SKOLEM_COUNT_EN: full scan, also reports the number of satisfying x.
module bvashr_cmp_skolem_seq
  import skolem_pkg::*;
#(
  parameter  int W  = 4,
  localparam int XW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_s,
  input  logic [W-1:0]  in_t,
  input  logic [1:0]    in_cmp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_found,
  output logic [W-1:0]  out_x
`ifdef SKOLEM_COUNT_EN
  ,
  output logic [XW:0]   out_cnt
`endif
);

  state_e        state;
  logic [W-1:0]  s_q;
  logic [W-1:0]  t_q;
  cmp_e          cmp_q;
  logic [XW-1:0] cand;
  logic          p;
  logic          last_cand;

  skolem_ashr_cmp #(.W(W)) u_pred (
    .s   (s_q),
    .t   (t_q),
    .x   (cand),
    .cmp (cmp_q),
    .p   (p)
  );

  assign last_cand = (cand == XW'(W - 1));
  assign in_ready  = rst_n && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_q       <= '0;
      t_q       <= '0;
      cmp_q     <= CMP_SLE;
      cand      <= '0;
      out_valid <= 1'b0;
      out_found <= 1'b0;
      out_x     <= '0;
`ifdef SKOLEM_COUNT_EN
      out_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            s_q       <= in_s;
            t_q       <= in_t;
            cmp_q     <= cmp_e'(in_cmp);
            cand      <= '0;
            out_found <= 1'b0;
            out_x     <= '0;
`ifdef SKOLEM_COUNT_EN
            out_cnt   <= '0;
`endif
            state     <= ST_SCAN;
          end
        end

        ST_SCAN: begin
`ifdef SKOLEM_COUNT_EN
          // Every candidate is visited; only the first hit sets the witness.
          if (p) begin
            out_cnt <= out_cnt + 1'b1;
            if (!out_found) begin
              out_found <= 1'b1;
              out_x     <= W'(cand);
            end
          end
          if (last_cand) begin
            out_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cand <= cand + 1'b1;
          end
`else
          if (p) begin
            out_found <= 1'b1;
            out_x     <= W'(cand);
            out_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (last_cand) begin
            out_found <= 1'b0;
            out_x     <= '0;
            out_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cand <= cand + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bvashr_cmp_skolem_seq.sv
// Self-checking bench for bvashr_cmp_skolem_seq (W=4): directed table, corner sequences,
// and random requests against an integer-arithmetic reference model.
module tb_bvashr_cmp_skolem_seq;
  localparam int W  = 4;
  localparam int XW = $clog2(W);
`ifdef SKOLEM_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_s;
  logic [W-1:0]  in_t;
  logic [1:0]    in_cmp;
  logic          out_valid;
  logic          out_ready;
  logic          out_found;
  logic [W-1:0]  out_x;
  logic [XW:0]   out_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bvashr_cmp_skolem_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_t      (in_t),
    .in_cmp    (in_cmp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_found (out_found),
    .out_x     (out_x)
`ifdef SKOLEM_COUNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

`ifndef SKOLEM_COUNT_EN
  assign out_cnt = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic [1:0]   cmp;
    int           found;
    int           x;
    int           cnt;
    int           lat;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: floor division by 2^x on plain integers, then a signed integer compare.
  function automatic void model(input logic [W-1:0] s, input logic [W-1:0] t, input logic [1:0] cmp,
                                output int found, output int x, output int cnt, output int lat);
    int sv, tv, v, p2;
    bit ok;
    sv = s[W-1] ? int'(s) - (1 << W) : int'(s);
    tv = t[W-1] ? int'(t) - (1 << W) : int'(t);
    found = 0; x = 0; cnt = 0;
    for (int xi = 0; xi < W; xi++) begin
      p2 = 1 << xi;
      v  = (sv >= 0) ? sv / p2 : -((-sv + p2 - 1) / p2);
      case (cmp)
        2'd0:    ok = (v <= tv);
        2'd1:    ok = (v <  tv);
        2'd2:    ok = (v >= tv);
        default: ok = (v >  tv);
      endcase
      if (ok) begin
        cnt++;
        if (found == 0) begin
          found = 1;
          x = xi;
        end
      end
    end
    lat = (CNT_EN || found == 0) ? W : x + 1;
  endfunction

  // Called at #1 after a posedge with the DUT idle; returns edges from acceptance to out_valid.
  task automatic apply_stimulus(input logic [W-1:0] s, input logic [W-1:0] t, input logic [1:0] cmp,
                                input int hold, output int found, output int x, output int cnt,
                                output int lat);
    logic         f0;
    logic [W-1:0] x0;
    in_s = s; in_t = t; in_cmp = cmp; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cmp = ~cmp;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check_output("response_timeout", 32'(out_valid), 32'd1);
    found = int'(out_found);
    x     = int'(out_x);
    cnt   = int'(out_cnt);
    f0 = out_found;
    x0 = out_x;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output("hold_stable", {29'd0, out_valid, out_found, (out_x == x0)}, {29'd0, 1'b1, f0, 1'b1});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output("idle_after_accept", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] s, input logic [W-1:0] t,
                               input logic [1:0] cmp, input int hold,
                               input int ef, input int ex, input int ec, input int el);
    int f, x, c, l;
    apply_stimulus(s, t, cmp, hold, f, x, c, l);
    check_output({tag, "_found"}, 32'(f), 32'(ef));
    check_output({tag, "_x"},     32'(x), 32'(ex));
    check_output({tag, "_lat"},   32'(l), 32'(el));
`ifdef SKOLEM_COUNT_EN
    check_output({tag, "_cnt"},   32'(c), 32'(ec));
`endif
  endtask

  vec_t vecs[6];

  initial begin
    int ef, ex, ec, el;
    logic [W-1:0] rs, rt;
    logic [1:0]   rc;

    vecs[0] = '{4'b1000, 4'b1100, 2'd0, 1, 0, 2, CNT_EN ? W : 1};
    vecs[1] = '{4'b0111, 4'b0001, 2'd0, 1, 2, 2, CNT_EN ? W : 3};
    vecs[2] = '{4'b1000, 4'b1110, 2'd3, 1, 3, 1, W};
    vecs[3] = '{4'b0111, 4'b1111, 2'd0, 0, 0, 0, W};
    vecs[4] = '{4'b0000, 4'b0000, 2'd1, 0, 0, 0, W};
    vecs[5] = '{4'b1111, 4'b1111, 2'd2, 1, 0, 4, CNT_EN ? W : 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_s = '0; in_t = '0; in_cmp = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", {28'd0, in_ready, out_valid, out_found, |out_x}, 32'd0);
    check_output("reset_cnt", 32'(out_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("ready_after_reset", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].t, vecs[i].cmp, i % 2,
                    vecs[i].found, vecs[i].x, vecs[i].cnt, vecs[i].lat);

    // Backpressure with a new request waiting: response held, second request accepted after.
    in_s = 4'b1000; in_t = 4'b1100; in_cmp = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_s = 4'b0111; in_t = 4'b0001; in_cmp = 2'd0;
    while (!out_valid && n_tests < 100000) begin
      @(posedge clk); #1;
      if (!out_valid) check_output("bp_wait_ready", 32'(in_ready), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      check_output("bp_stable", {28'd0, out_valid, out_found, |out_x, in_ready}, {28'd0, 4'b1100});
      @(posedge clk); #1;
    end
    check_output("bp_still_held", {30'd0, out_valid, in_ready}, 32'b10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output("bp_no_bypass", {30'd0, out_valid, in_ready}, 32'b01);
    run_and_check("bp_second", 4'b0111, 4'b0001, 2'd0, 0, 1, 2, 2, CNT_EN ? W : 3);

    // Reset in the middle of a scan aborts without a response.
    in_s = 4'b0111; in_t = 4'b1111; in_cmp = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("abort_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("abort_idle", {30'd0, out_valid, in_ready}, 32'b01);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check_output("abort_no_resp", 32'(out_valid), 32'd0);
    end
    run_and_check("after_abort", 4'b0111, 4'b0001, 2'd0, 0, 1, 2, 2, CNT_EN ? W : 3);

    for (int i = 0; i < 40; i++) begin
      rs = W'($urandom);
      rt = W'($urandom);
      rc = 2'($urandom_range(0, 3));
      model(rs, rt, rc, ef, ex, ec, el);
      run_and_check($sformatf("rand%0d", i), rs, rt, rc, int'($urandom_range(0, 2)), ef, ex, ec, el);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
